// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, register-index width and the flush NOP.
// Pure definitions; no timing or flow control.
package mips_pkg;
  localparam int          REG_AW    = 5;
  localparam logic [5:0]  OP_RTYPE  = 6'h00;
  localparam logic [5:0]  OP_BEQ    = 6'h04;
  localparam logic [5:0]  OP_BNE    = 6'h05;
  localparam logic [5:0]  OP_J      = 6'h02;
  localparam logic [5:0]  OP_LW     = 6'h23;
  localparam logic [5:0]  OP_SW     = 6'h2B;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
endpackage

// File: rtl/register_file.sv
// 32-entry 2R1W register file, r0 hard-wired to zero; reads combinational, write on clk.
// REGFILE_BYPASS_EN makes a same-cycle write visible on the read ports (write-first).
module register_file
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);
  logic [DATA_W-1:0] regs [32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign rdata_a = (raddr_a == '0) ? '0 : (we && waddr == raddr_a) ? wdata : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : (we && waddr == raddr_b) ? wdata : regs[raddr_b];
`else
  assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];
`endif
endmodule

// File: rtl/instruction_decode.sv
// Decode stage: IF/ID register, register file, branch/jump resolution, hazard stall; IF/ID->ID/EX is 2 edges.
// Stall holds IF/ID (pc_en=0) and pushes a bubble into ID/EX; optional REGFILE_BYPASS_EN in register_file.
module instruction_decode
  import mips_pkg::*;
#(
  parameter int          PC_W      = 10,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   if_pc_plus4,
  input  logic [31:0]       if_instr,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [4:0]        ex_dest,
  input  logic              mem_mem_read,
  input  logic [4:0]        mem_dest,
  output logic              pc_en,
  output logic              branch_taken,
  output logic [PC_W-1:0]   branch_address,
  output logic              jump,
  output logic [PC_W-1:0]   jump_address,
  output logic              idex_valid,
  output logic [PC_W-1:0]   idex_pc_plus4,
  output logic [DATA_W-1:0] idex_rs_data,
  output logic [DATA_W-1:0] idex_rt_data,
  output logic [31:0]       idex_imm,
  output logic [4:0]        idex_rs,
  output logic [4:0]        idex_rt,
  output logic [4:0]        idex_rd,
  output logic [5:0]        idex_opcode,
  output logic [5:0]        idex_funct
);
  logic [31:0]       ifid_instr;
  logic [PC_W-1:0]   ifid_pc_plus4;
  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, rd;
  logic [31:0]       imm_ext;
  logic [DATA_W-1:0] rs_data, rt_data;
  logic              is_branch, rt_is_src, load_use, branch_hazard, stall;

  assign opcode  = ifid_instr[31:26];
  assign rs      = ifid_instr[25:21];
  assign rt      = ifid_instr[20:16];
  assign rd      = ifid_instr[15:11];
  assign funct   = ifid_instr[5:0];
  assign imm_ext = {{16{ifid_instr[15]}}, ifid_instr[15:0]};

  register_file #(.DATA_W(DATA_W)) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_we),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rs_data),
    .rdata_b (rt_data)
  );

  assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign rt_is_src = is_branch || (opcode == OP_RTYPE) || (opcode == OP_SW);

  assign load_use = ex_mem_read && (ex_dest != '0) &&
                    ((ex_dest == rs) || (rt_is_src && ex_dest == rt));

  // Branches compare in decode, so any in-flight producer of their operands must drain first.
  assign branch_hazard = is_branch &&
      ((ex_reg_write && (ex_dest != '0) && ((ex_dest == rs) || (ex_dest == rt))) ||
       (mem_mem_read && (mem_dest != '0) && ((mem_dest == rs) || (mem_dest == rt))));

  assign stall = load_use || branch_hazard;
  assign pc_en = !stall;

  assign branch_taken = !stall &&
      (((opcode == OP_BEQ) && (rs_data == rt_data)) ||
       ((opcode == OP_BNE) && (rs_data != rt_data)));
  assign branch_address = ifid_pc_plus4 + {imm_ext[PC_W-3:0], 2'b00};
  assign jump           = !stall && (opcode == OP_J);
  assign jump_address   = {ifid_instr[PC_W-3:0], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_instr    <= NOP_INSTR;
      ifid_pc_plus4 <= '0;
    end else if (!stall) begin
      ifid_instr    <= (branch_taken || jump) ? NOP_INSTR : if_instr;
      ifid_pc_plus4 <= if_pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset || stall) begin
      idex_valid    <= 1'b0;
      idex_pc_plus4 <= '0;
      idex_rs_data  <= '0;
      idex_rt_data  <= '0;
      idex_imm      <= '0;
      idex_rs       <= '0;
      idex_rt       <= '0;
      idex_rd       <= '0;
      idex_opcode   <= '0;
      idex_funct    <= '0;
    end else begin
      idex_valid    <= 1'b1;
      idex_pc_plus4 <= ifid_pc_plus4;
      idex_rs_data  <= rs_data;
      idex_rt_data  <= rt_data;
      idex_imm      <= imm_ext;
      idex_rs       <= rs;
      idex_rt       <= rt;
      idex_rd       <= rd;
      idex_opcode   <= opcode;
      idex_funct    <= funct;
    end
  end
endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed steps then random traffic against a rule-level model.
// Honors REGFILE_BYPASS_EN when computing expected register reads.
module tb_instruction_decode;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  if_pc_plus4;
  logic [31:0] if_instr;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_mem_read, ex_reg_write, mem_mem_read;
  logic [4:0]  ex_dest, mem_dest;
  logic        pc_en, branch_taken, jump, idex_valid;
  logic [9:0]  branch_address, jump_address, idex_pc_plus4;
  logic [31:0] idex_rs_data, idex_rt_data, idex_imm;
  logic [4:0]  idex_rs, idex_rt, idex_rd;
  logic [5:0]  idex_opcode, idex_funct;

  instruction_decode dut (
    .clk(clk), .reset(reset), .if_pc_plus4(if_pc_plus4), .if_instr(if_instr),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_dest(ex_dest),
    .mem_mem_read(mem_mem_read), .mem_dest(mem_dest),
    .pc_en(pc_en), .branch_taken(branch_taken), .branch_address(branch_address),
    .jump(jump), .jump_address(jump_address), .idex_valid(idex_valid),
    .idex_pc_plus4(idex_pc_plus4), .idex_rs_data(idex_rs_data), .idex_rt_data(idex_rt_data),
    .idex_imm(idex_imm), .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
    .idex_opcode(idex_opcode), .idex_funct(idex_funct)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [9:0]  pc;
    logic [31:0] rs_d, rt_d, imm;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  op, fn;
  } idex_exp_t;

  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] mregs [32];
  logic [31:0] m_instr;
  logic [9:0]  m_pc;
  idex_exp_t   m_ex, ex_zero;
  logic        e_stall, e_bt, e_j;
  logic [9:0]  e_baddr, e_jaddr;
  logic [31:0] e_rsv, e_rtv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rdreg(input logic [4:0] a);
    if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wb_we && wb_addr == a) return wb_data;
`endif
    return mregs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    m_instr = 32'h0;
    m_pc    = 10'h0;
    m_ex    = ex_zero;
  endtask

  // Expected decode outputs straight from the rules, then compare every DUT output.
  task automatic compare_all();
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic       uses_rt, lu, bh;
    int         tgt;
    op = m_instr[31:26]; rs = m_instr[25:21]; rt = m_instr[20:16];
    e_rsv = rdreg(rs); e_rtv = rdreg(rt);
    uses_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
    lu = ex_mem_read && ex_dest != 0 && (ex_dest == rs || (uses_rt && ex_dest == rt));
    bh = (op == 6'h04 || op == 6'h05) &&
         ((ex_reg_write && ex_dest != 0 && (ex_dest == rs || ex_dest == rt)) ||
          (mem_mem_read && mem_dest != 0 && (mem_dest == rs || mem_dest == rt)));
    e_stall = lu || bh;
    e_bt = !e_stall && ((op == 6'h04 && e_rsv == e_rtv) || (op == 6'h05 && e_rsv != e_rtv));
    e_j  = !e_stall && (op == 6'h02);
    tgt = int'(m_pc) + 4 * int'($signed(m_instr[15:0]));
    e_baddr = tgt[9:0];
    e_jaddr = 10'(m_instr[7:0] * 4);
    chk("pc_en", pc_en, !e_stall);
    chk("branch_taken", branch_taken, e_bt);
    if (op == 6'h04 || op == 6'h05) chk("branch_address", branch_address, e_baddr);
    chk("jump", jump, e_j);
    if (op == 6'h02) chk("jump_address", jump_address, e_jaddr);
    chk("idex_valid", idex_valid, m_ex.v);
    chk("idex_pc_plus4", idex_pc_plus4, m_ex.pc);
    chk("idex_rs_data", idex_rs_data, m_ex.rs_d);
    chk("idex_rt_data", idex_rt_data, m_ex.rt_d);
    chk("idex_imm", idex_imm, m_ex.imm);
    chk("idex_regs", {idex_rs, idex_rt, idex_rd}, {m_ex.rs, m_ex.rt, m_ex.rd});
    chk("idex_op_funct", {idex_opcode, idex_funct}, {m_ex.op, m_ex.fn});
  endtask

  task automatic settle();
    @(negedge clk);
    compare_all();
  endtask

  task automatic tick();
    idex_exp_t   nx;
    logic [31:0] ni;
    logic [9:0]  np;
    nx = ex_zero;
    ni = m_instr; np = m_pc;
    if (!e_stall) begin
      nx.v = 1'b1; nx.pc = m_pc; nx.rs_d = e_rsv; nx.rt_d = e_rtv;
      nx.imm = {{16{m_instr[15]}}, m_instr[15:0]};
      nx.rs = m_instr[25:21]; nx.rt = m_instr[20:16]; nx.rd = m_instr[15:11];
      nx.op = m_instr[31:26]; nx.fn = m_instr[5:0];
      np = if_pc_plus4;
      ni = (e_bt || e_j) ? 32'h0 : if_instr;
    end
    @(posedge clk);
    if (reset) model_reset();
    else begin
      if (wb_we && wb_addr != 0) mregs[wb_addr] = wb_data;
      m_ex = nx; m_instr = ni; m_pc = np;
    end
    #1;
  endtask

  task automatic quiet();
    wb_we = 0; wb_addr = 0; wb_data = 0;
    ex_mem_read = 0; ex_reg_write = 0; ex_dest = 0; mem_mem_read = 0; mem_dest = 0;
  endtask

  task automatic step(input logic [9:0] pc, input logic [31:0] ins);
    if_pc_plus4 = pc; if_instr = ins;
    settle(); tick();
  endtask

  initial begin
    logic [5:0]  ops [7];
    logic [31:0] ri;
    logic [31:0] beq_i, j_i, add_i, bne_i;
    ops = '{6'h00, 6'h04, 6'h05, 6'h02, 6'h23, 6'h2B, 6'h08};
    ex_zero = '{default: '0};
    beq_i = {6'h04, 5'd8, 5'd9, 16'd3};
    j_i   = {6'h02, 26'h00000C4};
    add_i = {6'h00, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20};
    bne_i = {6'h05, 5'd8, 5'd0, 16'd2};
    model_reset();
    quiet();
    reset = 1; if_pc_plus4 = 0; if_instr = 0;
    settle(); tick(); tick();
    reset = 0;

    // Load r8 = r9 = 5.
    wb_we = 1; wb_addr = 8; wb_data = 5; step(10'h004, 32'h0);
    wb_addr = 9; step(10'h008, 32'h0);
    quiet();

    // beq taken; the slot behind it must flush.
    step(10'h010, beq_i);
    if_pc_plus4 = 10'h014; if_instr = 32'h2001_1234;
    settle();
    chk("beq_taken", branch_taken, 1'b1);
    chk("beq_target", branch_address, 10'h01C);
    tick();
    settle(); chk("beq_in_idex", idex_opcode, 6'h04); tick();
    settle(); chk("flushed_imm", idex_imm, 32'h0); tick();

    // Jump redirect.
    step(10'h020, j_i);
    if_pc_plus4 = 10'h024; if_instr = 32'h2001_5555;
    settle();
    chk("j_jump", jump, 1'b1);
    chk("j_target", jump_address, 10'h310);
    tick();
    step(10'h028, 32'h0);
    settle(); chk("j_flushed_imm", idex_imm, 32'h0); tick();

    // Load-use stall on add r10,r8,r9.
    step(10'h030, add_i);
    ex_mem_read = 1; ex_dest = 8; if_pc_plus4 = 10'h034; if_instr = 32'h0;
    settle(); chk("lu_stall", pc_en, 1'b0); tick();
    quiet();
    settle(); chk("lu_bubble", idex_valid, 1'b0); tick();
    settle(); chk("lu_issue_valid", idex_valid, 1'b1); chk("lu_issue_funct", idex_funct, 6'h20); tick();

    // bne with a pending load on its operand: one stall, then redirect.
    step(10'h040, bne_i);
    mem_mem_read = 1; mem_dest = 8; if_pc_plus4 = 10'h044; if_instr = 32'h0;
    settle(); chk("bne_stall", pc_en, 1'b0); chk("bne_no_redirect", branch_taken, 1'b0); tick();
    quiet();
    settle(); chk("bne_redirect", branch_taken, 1'b1); tick();
    step(10'h048, 32'h0);

    // Same-cycle writeback while reading rs=8; and r0 stays zero.
    step(10'h050, {6'h00, 5'd8, 5'd0, 5'd11, 5'd0, 6'h20});
    wb_we = 1; wb_addr = 8; wb_data = 32'hDEAD; if_instr = {6'h00, 5'd0, 5'd8, 5'd12, 5'd0, 6'h20};
    settle(); tick();
    wb_addr = 0; wb_data = 32'h1234; if_instr = 32'h0;
    settle();
`ifdef REGFILE_BYPASS_EN
    chk("bypass_rs", idex_rs_data, 32'hDEAD);
`else
    chk("nobypass_rs", idex_rs_data, 32'h5);
`endif
    tick();
    quiet();
    settle(); chk("r0_read", idex_rs_data, 32'h0); chk("r8_new", idex_rt_data, 32'hDEAD); tick();

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      ri = $urandom;
      ri[31:26] = ops[$urandom_range(0, 6)];
      ri[25:21] = 5'($urandom_range(0, 5));
      ri[20:16] = 5'($urandom_range(0, 5));
      wb_we = ($urandom_range(0, 1) == 1); wb_addr = 5'($urandom_range(0, 5)); wb_data = $urandom_range(0, 3);
      ex_mem_read = ($urandom_range(0, 3) == 0); ex_reg_write = ($urandom_range(0, 2) == 0);
      ex_dest = 5'($urandom_range(0, 5));
      mem_mem_read = ($urandom_range(0, 3) == 0); mem_dest = 5'($urandom_range(0, 5));
      step(10'($urandom), ri);
    end
    quiet();

    // Asynchronous reset while a taken beq sits in IF/ID.
    wb_we = 1; wb_addr = 8; wb_data = 7; step(10'h100, 32'h0);
    wb_addr = 9; step(10'h104, 32'h0);
    quiet();
    step(10'h108, beq_i);
    if_instr = 32'h0;
    settle();
    chk("pre_reset_taken", branch_taken, 1'b1);
    #2 reset = 1;
    #1 model_reset();
    compare_all();
    chk("rst_valid", idex_valid, 1'b0);
    chk("rst_pc_en", pc_en, 1'b1);
    chk("rst_branch", branch_taken, 1'b0);
    tick();
    reset = 0;
    settle(); tick();
    settle(); chk("post_reset_valid", idex_valid, 1'b1); chk("post_reset_op", idex_opcode, 6'h00); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Stage directly downstream of the fetch stage.
- Holds the IF/ID pipeline register and the 32x32 register file.
- Resolves beq/bne/j in decode and returns branch_taken, branch_address, jump, jump_address and pc_en to fetch.
- Detects load-use and branch-operand hazards, inserts bubbles, and drives a registered ID/EX bundle to execute.

Parameters:
- PC_W, 10, width of PC and all instruction addresses
- DATA_W, 32, register and instruction width
- NOP_INSTR, 32'h0000_0000, instruction injected on flush

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- if_pc_plus4  input  PC_W  pc_plus4 from fetch
- if_instr  input  32  fetched instruction
- wb_we  input  1  writeback register write enable
- wb_addr  input  5  writeback destination
- wb_data  input  32  writeback data
- ex_mem_read  input  1  instruction in EX is a load
- ex_reg_write  input  1  instruction in EX writes a register
- ex_dest  input  5  EX destination register
- mem_mem_read  input  1  instruction in MEM is a load
- mem_dest  input  5  MEM destination register
- pc_en  output  1  1 = fetch PC advances; 0 = PC holds
- branch_taken  output  1  combinational branch redirect
- branch_address  output  PC_W  branch target
- jump  output  1  combinational jump redirect
- jump_address  output  PC_W  jump target
- idex_valid  output  1  ID/EX holds a real instruction (0 = bubble)
- idex_pc_plus4  output  PC_W  registered
- idex_rs_data, idex_rt_data  output  32  registered operands
- idex_imm  output  32  registered sign-extended instr[15:0]
- idex_rs, idex_rt, idex_rd  output  5  registered fields
- idex_opcode, idex_funct  output  6  registered fields

Behaviour:
- Reset (async, immediate):
  - IF/ID instr = NOP_INSTR, pc_plus4 = 0.
  - All register-file entries = 0.
  - All idex_* outputs = 0, idex_valid = 0.
  - Reset mid-stall or mid-flush discards that state; next cycle is a normal decode of NOP.
- Fields from IF/ID instr:
  - opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0], imm [15:0].
- Decode classes:
  - beq = 6'h04, bne = 6'h05, j = 6'h02, lw = 6'h23.
  - rt is a source for R-type (opcode 0), beq, bne, sw (6'h2B).
- Register file:
  - Two combinational reads, write on posedge clk when wb_we.
  - Register 0 reads 0 and ignores writes.
- Hazards (combinational, stall = 1 for the cycle):
  - Load-use: ex_mem_read and ex_dest != 0 and (ex_dest == rs, or ex_dest == rt with rt as source).
  - Branch operand: opcode is beq/bne and either:
    - ex_reg_write and ex_dest != 0 and ex_dest matches rs or rt, or
    - mem_mem_read and mem_dest != 0 and mem_dest matches rs or rt.
- Stall:
  - pc_en = 0, IF/ID holds.
  - ID/EX loads a bubble: all fields 0, idex_valid = 0.
  - branch_taken = 0 and jump = 0 while stalled.
- Branch/jump resolution (when not stalled):
  - branch_taken = (beq and rs_data == rt_data) or (bne and rs_data != rt_data).
  - branch_address = IF/ID pc_plus4 + (sign-ext imm << 2), truncated to PC_W, wraps modulo 2^PC_W.
  - jump = (opcode == j); jump_address = {instr[PC_W-3:0], 2'b00}.
- Flush:
  - When branch_taken or jump, the next edge loads IF/ID with NOP_INSTR instead of if_instr.
  - pc_en remains 1.
  - The branch/jump itself still enters ID/EX with idex_valid = 1.
- Normal edge: IF/ID <= {if_pc_plus4, if_instr}; ID/EX <= decoded fields, idex_valid = 1.
  - A NOP in IF/ID propagates with idex_valid = 1 (harmless).
- Latency: IF/ID input to idex_* = 2 edges; redirect to fetch is in the same cycle as decode.
- Stall and redirect at the same time: stall wins; no redirect, no flush.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
  - Defined: read port returns wb_data when wb_we and wb_addr == read address != 0 (write-first).
  - Undefined: reads return the pre-write value in that cycle. The writeback stage must then add one cycle of separation; the hazard logic is unchanged.

Decomposition:
- Shared package mips_pkg:
  - Opcode constants OP_RTYPE, OP_BEQ, OP_BNE, OP_J, OP_LW, OP_SW.
  - NOP_INSTR value.
  - Register-index width constant REG_AW = 5.
- Sub-module register_file: 32 x DATA_W, 2R1W, zero register, bypass under REGFILE_BYPASS_EN.

Test Plan:
- Reset asserted mid-operation with IF/ID holding a beq -> idex_* = 0, idex_valid = 0, pc_en = 1, branch_taken = 0 immediately.
- Write r8 = 5 and r9 = 5 via WB; feed beq r8,r9,imm = 3 at pc_plus4 = 0x010 -> branch_taken = 1, branch_address = 0x01C; next IF/ID instr = 0.
- Feed j with instr[25:0] = 26'h0000_0C4 -> jump = 1, jump_address = 10'h310; following slot flushed to NOP.
- ex_mem_read = 1, ex_dest = 8; decode add r10,r8,r9 -> pc_en = 0 for one cycle, idex_valid = 0; next cycle the add issues with idex_valid = 1.
- bne r8,r0 with mem_mem_read = 1, mem_dest = 8 -> one stall, no redirect; next cycle redirect evaluated.
- wb_we = 1, wb_addr = 8, wb_data = 0xDEAD while decoding rs = 8 -> idex_rs_data = 0xDEAD with bypass, old value without; write to r0 always reads 0.
